// File: rtl/simple_edge_ai_soc_pkg.sv
`timescale 1ns/1ps
// Shared constants and types for the edge-AI SoC shell.
package simple_edge_ai_soc_pkg;

   localparam int unsigned CLK_HZ           = 100_000_000;
   localparam int unsigned BAUD             = 115_200;
   localparam int unsigned DEFAULT_BAUD_DIV = CLK_HZ / BAUD;   // 868
   localparam int unsigned FIFO_DEPTH       = 16;
   localparam int unsigned CTRL_TX_EN       = 0;
   localparam int unsigned CTRL_RX_EN       = 1;
   localparam int unsigned DATA_W           = 8;
   localparam int unsigned GPIO_W           = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/simple_edge_ai_soc_if.sv
`timescale 1ns/1ps
// Board-level pin bundle of the SoC: UART, LCD-SPI, GPIO and interrupt lines.
interface simple_edge_ai_soc_if;
   import simple_edge_ai_soc_pkg::*;

   logic              uart_tx;
   logic              uart_rx;
   logic              lcd_spi_clk;
   logic              lcd_spi_mosi;
   logic              lcd_spi_cs;
   logic              lcd_spi_dc;
   logic              lcd_spi_rst;
   logic              lcd_backlight;
   logic [GPIO_W-1:0] gpio_out;
   logic [GPIO_W-1:0] gpio_in;
   logic              trap;
   logic              compact_irq;
   logic              bitnet_irq;
   logic              uart_tx_irq;
   logic              uart_rx_irq;

   // SoC side drives the pins out.
   modport master (
      output uart_tx, lcd_spi_clk, lcd_spi_mosi, lcd_spi_cs, lcd_spi_dc, lcd_spi_rst,
             lcd_backlight, gpio_out, trap, compact_irq, bitnet_irq, uart_tx_irq, uart_rx_irq,
      input  uart_rx, gpio_in
   );

   // Board side observes the pins and drives the inputs.
   modport slave (
      input  uart_tx, lcd_spi_clk, lcd_spi_mosi, lcd_spi_cs, lcd_spi_dc, lcd_spi_rst,
             lcd_backlight, gpio_out, trap, compact_irq, bitnet_irq, uart_tx_irq, uart_rx_irq,
      output uart_rx, gpio_in
   );

endinterface

// File: rtl/edge_fifo.sv
`timescale 1ns/1ps
// Generic synchronous first-word fall-through FIFO (DEPTH a power of 2).
module edge_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enq_valid,
   input  logic [WIDTH-1:0] enq_data,
   output logic             enq_ready,
   output logic             deq_valid,
   output logic [WIDTH-1:0] deq_data,
   input  logic             deq_ready
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             do_enq;
   logic             do_deq;

   assign enq_ready = (cnt != CNT_W'(DEPTH));
   assign deq_valid = (cnt != '0);
   assign deq_data  = mem[rd_ptr];
   assign do_enq    = enq_valid && enq_ready;
   assign do_deq    = deq_ready && deq_valid;

   // Pointer and occupancy bookkeeping; push+pop together leaves the count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_enq) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_deq) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_enq, do_deq})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage array; occupancy gates every read so contents need no reset.
   always_ff @(posedge clk) begin
      if (do_enq) mem[wr_ptr] <= enq_data;
   end

endmodule

// File: rtl/edge_uart.sv
`timescale 1ns/1ps
// 8N1 UART: synchronised RX engine, TX engine and one FIFO per direction.
module edge_uart
   import simple_edge_ai_soc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              uart_rx,
   output logic              uart_tx,
   output logic              rx_valid,
   output logic [DATA_W-1:0] rx_data,
   input  logic              rx_ready,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              rx_irq,
   output logic              tx_irq,
   output logic              trap
);

   localparam int unsigned TMR_W = 32;
   localparam int unsigned BIT_W = 3;

   logic             rx_en;
   logic             tx_en;
   logic [TMR_W-1:0] baud_div;

   // Configuration registers, kept in a scope named so they read as uart.uart.control/baudDiv.
   if (1'b1) begin : uart
      logic [31:0] control;
      logic [31:0] baudDiv;
      logic        control_unused;

      // Fixed after reset; there is no bus port to rewrite them.
      always_ff @(posedge clk) begin
         if (rst) begin
            control <= (32'(1) << CTRL_TX_EN) | (32'(1) << CTRL_RX_EN);
            baudDiv <= 32'(DEFAULT_BAUD_DIV);
         end
      end

      assign rx_en          = control[CTRL_RX_EN];
      assign tx_en          = control[CTRL_TX_EN];
      assign baud_div       = baudDiv;
      assign control_unused = ^control[31:2];
   end

   // ---------------- RX path ----------------
   logic              rx_s1, rx_s2, rx_prev;
   uart_state_e       rx_state, rx_state_nx;
   logic [TMR_W-1:0]  rx_cnt, rx_cnt_nx;
   logic [BIT_W-1:0]  rx_bit, rx_bit_nx;
   logic [DATA_W-1:0] rx_shift, rx_shift_nx;
   logic              rx_push;
   logic              rx_fifo_ready;
   logic              trap_set;

   // Two-flop synchroniser plus edge-detect history, idling high.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= uart_rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // RX state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state <= IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_state <= rx_state_nx;
         rx_cnt   <= rx_cnt_nx;
         rx_bit   <= rx_bit_nx;
         rx_shift <= rx_shift_nx;
      end
   end

   // RX next state: half-bit to mid start bit, then one sample per bit period.
   always_comb begin
      rx_state_nx = rx_state;
      rx_cnt_nx   = rx_cnt;
      rx_bit_nx   = rx_bit;
      rx_shift_nx = rx_shift;
      rx_push     = 1'b0;
      trap_set    = 1'b0;
      case (rx_state)
         IDLE: begin
            if (rx_en && rx_prev && !rx_s2) begin
               rx_state_nx = START;
               rx_cnt_nx   = baud_div >> 1;
            end
         end
         START: begin
            if (rx_cnt == '0) begin
               if (!rx_s2) begin
                  rx_state_nx = DATA;
                  rx_cnt_nx   = baud_div - TMR_W'(1);
                  rx_bit_nx   = '0;
               end else begin
                  rx_state_nx = IDLE;
               end
            end else begin
               rx_cnt_nx = rx_cnt - TMR_W'(1);
            end
         end
         DATA: begin
            if (rx_cnt == '0) begin
               rx_shift_nx = {rx_s2, rx_shift[DATA_W-1:1]};
               rx_cnt_nx   = baud_div - TMR_W'(1);
               if (rx_bit == BIT_W'(DATA_W - 1)) rx_state_nx = STOP;
               else                              rx_bit_nx   = rx_bit + BIT_W'(1);
            end else begin
               rx_cnt_nx = rx_cnt - TMR_W'(1);
            end
         end
         STOP: begin
            if (rx_cnt == '0) begin
               rx_state_nx = IDLE;
               if (rx_s2 && rx_fifo_ready) rx_push  = 1'b1;
               else                        trap_set = 1'b1;
            end else begin
               rx_cnt_nx = rx_cnt - TMR_W'(1);
            end
         end
         default: rx_state_nx = IDLE;
      endcase
   end

   // Sticky error flag: framing error or RX overflow.
   always_ff @(posedge clk) begin
      if (rst)           trap <= 1'b0;
      else if (trap_set) trap <= 1'b1;
   end

   edge_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) rx_fifo (
      .clk       (clk),
      .rst       (rst),
      .enq_valid (rx_push),
      .enq_data  (rx_shift),
      .enq_ready (rx_fifo_ready),
      .deq_valid (rx_valid),
      .deq_data  (rx_data),
      .deq_ready (rx_ready)
   );

   // ---------------- TX path ----------------
   uart_state_e       tx_state, tx_state_nx;
   logic [TMR_W-1:0]  tx_cnt, tx_cnt_nx;
   logic [BIT_W-1:0]  tx_bit, tx_bit_nx;
   logic [DATA_W-1:0] tx_shift, tx_shift_nx;
   logic              tx_line_nx;
   logic              tx_pop;
   logic              tx_go_c;
   logic              tx_fifo_valid;
   logic [DATA_W-1:0] tx_fifo_data;

   assign tx_go_c = tx_en && tx_fifo_valid;

   // TX state register; line forced high by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         uart_tx  <= 1'b1;
      end else begin
         tx_state <= tx_state_nx;
         tx_cnt   <= tx_cnt_nx;
         tx_bit   <= tx_bit_nx;
         tx_shift <= tx_shift_nx;
         uart_tx  <= tx_line_nx;
      end
   end

   // TX next state: each symbol lasts one bit period; STOP chains straight into the next byte.
   always_comb begin
      tx_state_nx = tx_state;
      tx_cnt_nx   = tx_cnt;
      tx_bit_nx   = tx_bit;
      tx_shift_nx = tx_shift;
      tx_line_nx  = uart_tx;
      tx_pop      = 1'b0;
      case (tx_state)
         IDLE: begin
            tx_line_nx = 1'b1;
            if (tx_go_c) begin
               tx_pop      = 1'b1;
               tx_shift_nx = tx_fifo_data;
               tx_line_nx  = 1'b0;
               tx_cnt_nx   = baud_div - TMR_W'(1);
               tx_state_nx = START;
            end
         end
         START: begin
            if (tx_cnt == '0) begin
               tx_state_nx = DATA;
               tx_line_nx  = tx_shift[0];
               tx_bit_nx   = '0;
               tx_cnt_nx   = baud_div - TMR_W'(1);
            end else begin
               tx_cnt_nx = tx_cnt - TMR_W'(1);
            end
         end
         DATA: begin
            if (tx_cnt == '0) begin
               tx_cnt_nx = baud_div - TMR_W'(1);
               if (tx_bit == BIT_W'(DATA_W - 1)) begin
                  tx_state_nx = STOP;
                  tx_line_nx  = 1'b1;
               end else begin
                  tx_bit_nx   = tx_bit + BIT_W'(1);
                  tx_shift_nx = tx_shift >> 1;
                  tx_line_nx  = tx_shift[1];
               end
            end else begin
               tx_cnt_nx = tx_cnt - TMR_W'(1);
            end
         end
         STOP: begin
            if (tx_cnt == '0) begin
               if (tx_go_c) begin
                  tx_pop      = 1'b1;
                  tx_shift_nx = tx_fifo_data;
                  tx_line_nx  = 1'b0;
                  tx_cnt_nx   = baud_div - TMR_W'(1);
                  tx_state_nx = START;
               end else begin
                  tx_line_nx  = 1'b1;
                  tx_state_nx = IDLE;
               end
            end else begin
               tx_cnt_nx = tx_cnt - TMR_W'(1);
            end
         end
         default: tx_state_nx = IDLE;
      endcase
   end

   edge_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) tx_fifo (
      .clk       (clk),
      .rst       (rst),
      .enq_valid (tx_valid),
      .enq_data  (tx_data),
      .enq_ready (tx_ready),
      .deq_valid (tx_fifo_valid),
      .deq_data  (tx_fifo_data),
      .deq_ready (tx_pop)
   );

   assign rx_irq = rx_valid;
   assign tx_irq = !tx_fifo_valid && (tx_state == IDLE);

endmodule

// File: rtl/simple_edge_ai_soc.sv
`timescale 1ns/1ps
// SoC shell: UART with auto-echo, GPIO mirror and idle LCD-SPI pins.
module simple_edge_ai_soc
   import simple_edge_ai_soc_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   simple_edge_ai_soc_if.master io
);

   localparam int unsigned HALF_W = GPIO_W / 2;

   logic              uart_tx;
   logic              rx_valid;
   logic              rx_ready;
   logic [DATA_W-1:0] rx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] tx_data;
   logic              rx_irq;
   logic              tx_irq;
   logic              trap;
   logic              echo_c;
   logic [HALF_W-1:0] gpio_s1;
   logic [HALF_W-1:0] gpio_s2;
   logic [GPIO_W-1:0] gpio_out;
   logic              lcd_on;
   logic              gpio_in_unused;

   edge_uart uart (
      .clk      (clock),
      .rst      (reset),
      .uart_rx  (io.uart_rx),
      .uart_tx  (uart_tx),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .rx_irq   (rx_irq),
      .tx_irq   (tx_irq),
      .trap     (trap)
   );

   // Echo engine: move one byte RX->TX whenever RX has data and TX has room.
   assign echo_c   = rx_valid && tx_ready;
   assign rx_ready = echo_c;
   assign tx_valid = echo_c;
   assign tx_data  = rx_data;

   // Synchroniser for the asynchronous GPIO inputs mirrored on the upper half.
   always_ff @(posedge clock) begin
      if (reset) begin
         gpio_s1 <= '0;
         gpio_s2 <= '0;
      end else begin
         gpio_s1 <= io.gpio_in[HALF_W-1:0];
         gpio_s2 <= gpio_s1;
      end
   end

   // GPIO output: last echoed byte, echo count, and mirrored inputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         gpio_out <= '0;
      end else begin
         gpio_out[GPIO_W-1:HALF_W] <= gpio_s2;
         if (echo_c) begin
            gpio_out[DATA_W-1:0]          <= rx_data;
            gpio_out[2*DATA_W-1:DATA_W]   <= gpio_out[2*DATA_W-1:DATA_W] + DATA_W'(1);
         end
      end
   end

   // LCD reset/backlight held low while in reset, released afterwards.
   always_ff @(posedge clock) begin
      if (reset) lcd_on <= 1'b0;
      else       lcd_on <= 1'b1;
   end

   assign gpio_in_unused   = ^io.gpio_in[GPIO_W-1:HALF_W];

   assign io.uart_tx       = uart_tx;
   assign io.gpio_out      = gpio_out;
   assign io.trap          = trap;
   assign io.uart_rx_irq   = rx_irq;
   assign io.uart_tx_irq   = tx_irq;
   assign io.compact_irq   = 1'b0;
   assign io.bitnet_irq    = 1'b0;
   assign io.lcd_spi_clk   = 1'b0;
   assign io.lcd_spi_mosi  = 1'b0;
   assign io.lcd_spi_cs    = 1'b1;
   assign io.lcd_spi_dc    = 1'b0;
   assign io.lcd_spi_rst   = lcd_on;
   assign io.lcd_backlight = lcd_on;

endmodule

// File: tb/tb_simple_edge_ai_soc.sv
`timescale 1ns/1ps
// Scoreboard bench: stimulus queues expected bytes, monitors pop and compare.
module tb_simple_edge_ai_soc;

   localparam int unsigned BIT_NS = 8680;

   logic       clk = 1'b0;
   logic       rst;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_echo_q[$];
   logic [7:0] exp_line_q[$];
   logic       line_mon_en = 1'b1;
   logic [7:0] seq_model = 8'd0;
   logic       gpio_pend = 1'b0;
   logic [15:0] gpio_exp;
   logic [7:0] echo_byte;

   simple_edge_ai_soc_if io ();

   simple_edge_ai_soc dut (
      .clock (clk),
      .reset (rst),
      .io    (io)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Echo monitor: each RX pop / TX push must match the next queued byte.
   always @(negedge clk) begin
      if (rst) begin
         seq_model = 8'd0;
         gpio_pend = 1'b0;
      end else begin
         if (gpio_pend) begin
            check("gpio_lo_after_echo", 32'(io.gpio_out[15:0]), 32'(gpio_exp));
            gpio_pend = 1'b0;
         end
         if (dut.echo_c) begin
            if (exp_echo_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_echo actual=0x%02h expected=none", dut.rx_data);
            end else begin
               echo_byte = exp_echo_q.pop_front();
               check("rx_fifo_data", 32'(dut.rx_data), 32'(echo_byte));
               check("tx_fifo_write", 32'({dut.tx_valid, dut.tx_data}), 32'({1'b1, echo_byte}));
               seq_model = seq_model + 8'd1;
               gpio_exp  = {seq_model, echo_byte};
               gpio_pend = 1'b1;
            end
         end
      end
   end

   // TX line decoder: samples mid-bit and compares the frame against the queue.
   initial begin : line_monitor
      logic [9:0] frame;
      logic [7:0] exp_b;
      forever begin
         @(negedge io.uart_tx);
         if (line_mon_en) begin
            #(BIT_NS / 2);
            frame[0] = io.uart_tx;
            for (int i = 1; i < 10; i++) begin
               #(BIT_NS);
               frame[i] = io.uart_tx;
            end
            if (exp_line_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_tx_frame actual=0x%03h expected=none", frame);
            end else begin
               exp_b = exp_line_q.pop_front();
               check("tx_line_frame", 32'(frame), 32'({1'b1, exp_b, 1'b0}));
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      io.uart_rx = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 8; i++) begin
         io.uart_rx = b[i];
         #(BIT_NS);
      end
      io.uart_rx = stop_bit;
      #(BIT_NS);
      io.uart_rx = 1'b1;
   endtask

   task automatic wait_drain(input int max_cycles);
      int n = 0;
      while ((exp_echo_q.size() + exp_line_q.size()) != 0 && n < max_cycles) begin
         @(posedge clk);
         n++;
      end
      check("queues_drained", 32'(exp_echo_q.size() + exp_line_q.size()), 32'd0);
   endtask

   initial begin : watchdog
      #(900_000);
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      rst        = 1'b1;
      io.uart_rx = 1'b1;
      io.gpio_in = '0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("lcd_rst_in_reset", 32'(io.lcd_spi_rst), 32'd0);
      check("backlight_in_reset", 32'(io.lcd_backlight), 32'd0);
      rst = 1'b0;
      #1000;
      @(negedge clk);

      // Post-reset state.
      check("control", dut.uart.uart.control, 32'h0000_0003);
      check("baud_div", dut.uart.uart.baudDiv, 32'h0000_0364);
      check("uart_tx_idle", 32'(io.uart_tx), 32'd1);
      check("gpio_out_reset", io.gpio_out, 32'd0);
      check("lcd_cs", 32'(io.lcd_spi_cs), 32'd1);
      check("lcd_backlight", 32'(io.lcd_backlight), 32'd1);
      check("lcd_rst_released", 32'(io.lcd_spi_rst), 32'd1);
      check("lcd_clk_mosi_dc", 32'({io.lcd_spi_clk, io.lcd_spi_mosi, io.lcd_spi_dc}), 32'd0);
      check("irqs_reset", 32'({io.compact_irq, io.bitnet_irq, io.uart_rx_irq, io.uart_tx_irq}), 32'b0001);
      check("trap_reset", 32'(io.trap), 32'd0);

      // Three bytes with 50 us gaps; echoes must arrive in order.
      exp_echo_q.push_back(8'h55); exp_line_q.push_back(8'h55);
      send_byte(8'h55, 1'b1);
      #50_000;
      exp_echo_q.push_back(8'hAA); exp_line_q.push_back(8'hAA);
      send_byte(8'hAA, 1'b1);
      #50_000;
      exp_echo_q.push_back(8'h33); exp_line_q.push_back(8'h33);
      send_byte(8'h33, 1'b1);
      wait_drain(20_000);
      #(BIT_NS);
      @(negedge clk);
      check("gpio_lo_final", 32'(io.gpio_out[15:0]), 32'h0333);
      check("tx_irq_idle", 32'(io.uart_tx_irq), 32'd1);
      check("rx_irq_idle", 32'(io.uart_rx_irq), 32'd0);
      check("trap_clean", 32'(io.trap), 32'd0);

      // GPIO input mirror through the synchroniser.
      @(negedge clk);
      io.gpio_in = 32'h0000_BEEF;
      repeat (3) @(posedge clk);
      #1;
      check("gpio_mirror", io.gpio_out, 32'hBEEF_0333);

      // Framing error: no push, no echo, sticky trap.
      send_byte(8'hC3, 1'b0);
      #(2 * BIT_NS);
      @(negedge clk);
      check("trap_framing", 32'(io.trap), 32'd1);
      check("rx_irq_after_framing", 32'(io.uart_rx_irq), 32'd0);
      check("gpio_after_framing", io.gpio_out, 32'hBEEF_0333);
      #20_000;
      @(negedge clk);
      check("trap_sticky", 32'(io.trap), 32'd1);

      // Reset in the middle of a TX frame.
      line_mon_en = 1'b0;
      exp_echo_q.push_back(8'h5A);
      send_byte(8'h5A, 1'b1);
      wait_drain(100);
      #(3 * BIT_NS);
      @(negedge clk);
      check("tx_mid_frame_bit2", 32'(io.uart_tx), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("tx_forced_high", 32'(io.uart_tx), 32'd1);
      check("gpio_cleared", io.gpio_out, 32'd0);
      check("fifos_flushed", 32'({io.uart_rx_irq, io.uart_tx_irq}), 32'b01);
      check("trap_cleared", 32'(io.trap), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("tx_idle_after_reset", 32'(io.uart_tx), 32'd1);
      check("echo_queue_empty", 32'(exp_echo_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/simple_edge_ai_soc.md
Name: simple_edge_ai_soc

Overview:
- Minimal edge-AI SoC shell with one clock domain.
- Contains a UART with RX/TX FIFOs, an auto-echo command path, a GPIO block and idle LCD-SPI pins.
- Exposes status and interrupt lines. Accelerator IRQs are reserved and tied inactive.
- Every received UART byte is echoed on TX and reflected on gpio_out.

Parameters:
- CLK_HZ, 100000000, system clock frequency.
- BAUD, 115200, UART baud rate. Reset value of baudDiv is CLK_HZ/BAUD = 868.
- FIFO_DEPTH, 16, depth of each UART FIFO (power of 2).

Ports:
- clock  in  1  system clock, 100 MHz nominal.
- reset  in  1  synchronous, active-high reset.
- io_uart_tx  out  1  UART TX, 8N1, idles high.
- io_uart_rx  in  1  UART RX, 8N1, idles high.
- io_lcd_spi_clk  out  1  LCD SPI clock, held 0.
- io_lcd_spi_mosi  out  1  LCD SPI data, held 0.
- io_lcd_spi_cs  out  1  LCD chip select, held 1 (inactive).
- io_lcd_spi_dc  out  1  LCD data/command, held 0.
- io_lcd_spi_rst  out  1  LCD reset, active-low: 0 during reset, 1 afterwards.
- io_lcd_backlight  out  1  0 during reset, 1 afterwards.
- io_gpio_out  out  32  GPIO output register.
- io_gpio_in  in  32  GPIO inputs, asynchronous.
- io_trap  out  1  sticky error flag.
- io_compact_irq  out  1  reserved, constant 0.
- io_bitnet_irq  out  1  reserved, constant 0.
- io_uart_tx_irq  out  1  TX FIFO empty and transmitter idle.
- io_uart_rx_irq  out  1  RX FIFO not empty.

Behaviour:
- Reset values:
  - io_uart_tx=1, io_gpio_out=0, io_trap=0, both FIFOs empty.
  - control=0x00000003 (bit0 TX enable, bit1 RX enable).
  - baudDiv=868.
  - io_uart_rx_irq=0, io_uart_tx_irq=1.
- RX input: io_uart_rx passes through a 2-flop synchronizer, reset value 1.
- RX state machine IDLE→START→DATA→STOP:
  - IDLE: a synchronized 1→0 transition with control[1]=1 enters START and loads the counter with baudDiv/2.
  - START: at counter expiry, if the line is still 0, go to DATA. Otherwise (glitch) return to IDLE.
  - DATA: sample 8 bits LSB first, one every baudDiv cycles.
  - STOP: sample once after baudDiv cycles.
    - Stop=1: push the byte into the RX FIFO. If the FIFO is full, drop the byte and set io_trap.
    - Stop=0 (framing error): drop the byte and set io_trap.
  - Return to IDLE after STOP.
- Echo engine: whenever the RX FIFO is non-empty and the TX FIFO is not full, in the same cycle:
  - pop RX (rxFifo.io_deq_valid & ready);
  - push the same byte into TX (txFifo.io_enq_valid);
  - gpio_out[7:0] ← byte;
  - gpio_out[15:8] ← gpio_out[15:8]+1 (wraps 255→0).
- io_uart_rx_irq is therefore high for at most 1 cycle per byte unless TX backs up.
- gpio_out[31:16] ← io_gpio_in[15:0] through a 2-flop synchronizer; updated every cycle.
- TX state machine IDLE→START→DATA→STOP:
  - IDLE with control[0]=1 and TX FIFO non-empty: pop and drive 0 for baudDiv cycles.
  - DATA: 8 bits LSB first, baudDiv cycles each.
  - STOP: drive 1 for baudDiv cycles, then IDLE.
  - Back-to-back bytes have no extra idle gap.
- Byte latency: the first TX start bit begins ≤4 cycles after the RX stop-bit sample.
- Disables: control[1]=0 blocks new RX frames. control[0]=0 holds TX idle (line high), but a frame in progress completes.
- FIFOs: synchronous, first-word fall-through. Push while full is ignored; pop while empty is ignored. Simultaneous push+pop keeps the count unchanged.
- io_trap clears only on reset.
- Reset mid-frame aborts both state machines, flushes FIFOs and forces io_uart_tx=1 on the next edge.
- control and baudDiv are internal registers (no bus port) holding fixed values after reset. They must be readable by hierarchy as uart.uart.control and uart.uart.baudDiv.

Decomposition:
- Package simple_edge_ai_soc_pkg: CLK_HZ, BAUD, DEFAULT_BAUD_DIV=868, CTRL_TX_EN=0, CTRL_RX_EN=1, and the uart_state_e enum (IDLE, START, DATA, STOP).
- One natural sub-module: edge_uart, containing the RX/TX engines and two FIFO instances (edge_fifo, generic). It is instantiated as uart.uart.
- The top level holds the echo engine, GPIO logic and LCD tie-offs.

Test Plan:
- Reset release, wait 1000 ns:
  - control=0x00000003, baudDiv=0x00000364;
  - io_uart_tx=1, gpio_out=0;
  - io_lcd_spi_cs=1, io_lcd_backlight=1;
  - all IRQs except tx_irq are 0.
- Send 0x55 on RX at 8680 ns/bit:
  - an RX FIFO valid pulse with data 0x55;
  - a TX FIFO write of 0x55;
  - TX line decodes 0x55;
  - gpio_out[15:0]=0x0155.
- Send 0x55, 0xAA, 0x33 with 50 µs gaps:
  - echoes 0x55, 0xAA, 0x33 in order;
  - final gpio_out[15:0]=0x0333.
- gpio_in=0x0000BEEF → within 3 cycles gpio_out[31:16]=0xBEEF, lower bits unchanged.
- Frame with stop bit 0 → no FIFO push, no echo, io_trap=1, held until reset.
- Assert reset mid-TX frame → io_uart_tx=1 on the next edge; FIFOs empty; gpio_out=0.
